axi_mmu_ar_arbiter: RTL and testbench

AXI_MMU_AR_ARBITER -- requirements
Module: axi_mmu_ar_arbiter

---
 rtl/axi_mmu_ar_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_axi_mmu_ar_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mmu_ar_arbiter.sv
// Round-robin AR arbiter that merges device read masters into one SMMU-facing AR
// channel, tags each burst with stream/substream IDs and routes R beats back by ID.
module axi_mmu_ar_arbiter #(
  parameter int NumPorts       = 4,
  parameter int IdWidth        = 4,
  parameter int MaxOutstanding = 8,
  localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumPorts-1:0]          in_ar_valid_i,
  output logic [NumPorts-1:0]          in_ar_ready_o,
  input  logic [NumPorts*IdWidth-1:0]  in_ar_id_i,
  input  logic [NumPorts*64-1:0]       in_ar_addr_i,
  input  logic [NumPorts*8-1:0]        in_ar_len_i,
  input  logic [NumPorts*24-1:0]       sid_cfg_i,
  input  logic [NumPorts*20-1:0]       ssid_cfg_i,
  input  logic [NumPorts-1:0]          ssidv_cfg_i,
  output logic                         out_ar_valid_o,
  input  logic                         out_ar_ready_i,
  output logic [IdWidth+1:0]           out_ar_id_o,
  output logic [63:0]                  out_ar_addr_o,
  output logic [7:0]                   out_ar_len_o,
  output logic [23:0]                  out_ar_stream_id_o,
  output logic                         out_ar_ss_id_valid_o,
  output logic [19:0]                  out_ar_substream_id_o,
  input  logic                         out_r_valid_i,
  output logic                         out_r_ready_o,
  input  logic [IdWidth+1:0]           out_r_id_i,
  input  logic [63:0]                  out_r_data_i,
  input  logic [1:0]                   out_r_resp_i,
  input  logic                         out_r_last_i,
  output logic [NumPorts-1:0]          in_r_valid_o,
  input  logic [NumPorts-1:0]          in_r_ready_i,
  output logic [IdWidth-1:0]           in_r_id_o,
  output logic [63:0]                  in_r_data_o,
  output logic [1:0]                   in_r_resp_o,
  output logic                         in_r_last_o,
  output logic                         unexp_r_o,
  output logic                         dbg_state_o,
  output logic [1:0]                   dbg_rr_ptr_o,
  output logic [NumPorts*CntW-1:0]     dbg_count_o
);

  // All channels use AXI valid/ready: a beat transfers on a rising edge where both
  // are high; valid never waits on ready, and payload is held while valid && !ready.

  localparam int PortW = 2;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [PortW-1:0]      rr_ptr_q;
  logic [CntW-1:0]       cnt_q [NumPorts];
  logic [NumPorts-1:0]   eligible;
  logic                  grant_found;
  logic [PortW-1:0]      grant_idx;
  logic                  grant_fire;
  logic [PortW-1:0]      r_port;
  logic                  r_last_hs;
  logic [NumPorts-1:0]   inc;
  logic [NumPorts-1:0]   dec;
  int                    cand;

  always_comb begin
    eligible = '0;
    for (int p = 0; p < NumPorts; p++) begin
      eligible[p] = cnt_q[p] < CntW'(MaxOutstanding);
    end
  end

  // Round-robin search starting at rr_ptr over ports that are both requesting and under the limit.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NumPorts; i++) begin
      cand = (int'(rr_ptr_q) + i) % NumPorts;
      if (!grant_found && in_ar_valid_i[PortW'(cand)] && eligible[PortW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = PortW'(cand);
      end
    end
  end

  assign grant_fire = (state_q == IDLE) && grant_found && !rst_i;

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = HOLD;
      HOLD:    if (out_ar_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    out_ar_valid_o = (state_q == HOLD);
    in_ar_ready_o  = '0;
    if (grant_fire) in_ar_ready_o = NumPorts'(1) << grant_idx;
  end

  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q              <= '0;
      out_ar_id_o           <= '0;
      out_ar_addr_o         <= '0;
      out_ar_len_o          <= '0;
      out_ar_stream_id_o    <= '0;
      out_ar_ss_id_valid_o  <= 1'b0;
      out_ar_substream_id_o <= '0;
    end else if (grant_fire) begin
      rr_ptr_q              <= (grant_idx == PortW'(NumPorts - 1)) ? '0 : grant_idx + 1'b1;
      out_ar_id_o           <= {grant_idx, in_ar_id_i[grant_idx*IdWidth +: IdWidth]};
      out_ar_addr_o         <= in_ar_addr_i[grant_idx*64 +: 64];
      out_ar_len_o          <= in_ar_len_i[grant_idx*8 +: 8];
      out_ar_stream_id_o    <= sid_cfg_i[grant_idx*24 +: 24];
      out_ar_ss_id_valid_o  <= ssidv_cfg_i[grant_idx];
      out_ar_substream_id_o <= ssid_cfg_i[grant_idx*20 +: 20];
    end
  end

  // R path is pure routing on the port index carried in the upper ID bits.
  assign r_port      = out_r_id_i[IdWidth+1:IdWidth];
  assign in_r_id_o   = out_r_id_i[IdWidth-1:0];
  assign in_r_data_o = out_r_data_i;
  assign in_r_resp_o = out_r_resp_i;
  assign in_r_last_o = out_r_last_i;

  always_comb begin
    in_r_valid_o  = '0;
    out_r_ready_o = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      if (r_port == PortW'(p)) begin
        in_r_valid_o[p] = out_r_valid_i;
        out_r_ready_o   = in_r_ready_i[p];
      end
    end
  end

  assign r_last_hs = out_r_valid_i && out_r_ready_o && out_r_last_i;

  always_comb begin
    inc       = in_ar_ready_o;
    dec       = '0;
    unexp_r_o = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      dec[p] = r_last_hs && (r_port == PortW'(p));
      if (dec[p] && cnt_q[p] == '0 && !rst_i) unexp_r_o = 1'b1;
    end
  end

  // Simultaneous issue and retire on one port cancel; retire at zero saturates.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++) begin
      if (rst_i) begin
        cnt_q[p] <= '0;
      end else if (inc[p] && !dec[p]) begin
        cnt_q[p] <= cnt_q[p] + 1'b1;
      end else if (dec[p] && !inc[p] && cnt_q[p] != '0) begin
        cnt_q[p] <= cnt_q[p] - 1'b1;
      end
    end
  end

  always_comb begin
    dbg_count_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      dbg_count_o[p*CntW +: CntW] = cnt_q[p];
    end
  end

endmodule

// File: tb/tb_axi_mmu_ar_arbiter.sv
// Directed bench for axi_mmu_ar_arbiter: grant order, hold behaviour, outstanding
// limits, R routing, unexpected-R detection and reset abandonment.
module tb_axi_mmu_ar_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    in_ar_valid, in_ar_ready;
  logic [15:0]   in_ar_id;
  logic [255:0]  in_ar_addr;
  logic [31:0]   in_ar_len;
  logic [95:0]   sid_cfg;
  logic [79:0]   ssid_cfg;
  logic [3:0]    ssidv_cfg;
  logic          out_ar_valid, out_ar_ready;
  logic [5:0]    out_ar_id;
  logic [63:0]   out_ar_addr;
  logic [7:0]    out_ar_len;
  logic [23:0]   out_ar_stream_id;
  logic          out_ar_ss_id_valid;
  logic [19:0]   out_ar_substream_id;
  logic          out_r_valid, out_r_ready;
  logic [5:0]    out_r_id;
  logic [63:0]   out_r_data;
  logic [1:0]    out_r_resp;
  logic          out_r_last;
  logic [3:0]    in_r_valid, in_r_ready;
  logic [3:0]    in_r_id;
  logic [63:0]   in_r_data;
  logic [1:0]    in_r_resp;
  logic          in_r_last;
  logic          unexp_r;
  logic          dbg_state;
  logic [1:0]    dbg_rr_ptr;
  logic [15:0]   dbg_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_mmu_ar_arbiter #(.NumPorts(4), .IdWidth(4), .MaxOutstanding(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_ar_valid_i(in_ar_valid), .in_ar_ready_o(in_ar_ready),
    .in_ar_id_i(in_ar_id), .in_ar_addr_i(in_ar_addr), .in_ar_len_i(in_ar_len),
    .sid_cfg_i(sid_cfg), .ssid_cfg_i(ssid_cfg), .ssidv_cfg_i(ssidv_cfg),
    .out_ar_valid_o(out_ar_valid), .out_ar_ready_i(out_ar_ready),
    .out_ar_id_o(out_ar_id), .out_ar_addr_o(out_ar_addr), .out_ar_len_o(out_ar_len),
    .out_ar_stream_id_o(out_ar_stream_id), .out_ar_ss_id_valid_o(out_ar_ss_id_valid),
    .out_ar_substream_id_o(out_ar_substream_id),
    .out_r_valid_i(out_r_valid), .out_r_ready_o(out_r_ready), .out_r_id_i(out_r_id),
    .out_r_data_i(out_r_data), .out_r_resp_i(out_r_resp), .out_r_last_i(out_r_last),
    .in_r_valid_o(in_r_valid), .in_r_ready_i(in_r_ready), .in_r_id_o(in_r_id),
    .in_r_data_o(in_r_data), .in_r_resp_o(in_r_resp), .in_r_last_o(in_r_last),
    .unexp_r_o(unexp_r),
    .dbg_state_o(dbg_state), .dbg_rr_ptr_o(dbg_rr_ptr), .dbg_count_o(dbg_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    in_ar_valid = '0; out_ar_ready = 1'b0;
    out_r_valid = 1'b0; out_r_id = '0; out_r_data = '0; out_r_resp = '0;
    out_r_last = 1'b0; in_r_ready = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_ar_valid = 4'b1111;
    tick(); tick();
    checks++;
    if (in_ar_ready !== 4'b0000 || out_ar_valid !== 1'b0) begin
      errors++; $display("FAIL reset_handshake: ready=%b valid=%b exp 0000/0", in_ar_ready, out_ar_valid);
    end
    checks++;
    if (dbg_state !== 1'b0 || dbg_rr_ptr !== 2'd0 || dbg_count !== 16'h0000) begin
      errors++; $display("FAIL reset_state: state=%b rr=%0d cnt=%h exp 0/0/0000", dbg_state, dbg_rr_ptr, dbg_count);
    end
    in_ar_valid = '0;
    out_r_valid = 1'b1; out_r_id = 6'h1B; out_r_last = 1'b1; in_r_ready = 4'b0010;
    out_r_data = 64'h0123_4567_89AB_CDEF; out_r_resp = 2'b10;
    #1;
    checks++;
    if (in_r_valid !== 4'b0010 || in_r_id !== 4'hB || out_r_ready !== 1'b1) begin
      errors++; $display("FAIL reset_r_route: rvalid=%b rid=%h rready=%b exp 0010/b/1", in_r_valid, in_r_id, out_r_ready);
    end
    checks++;
    if (in_r_data !== 64'h0123_4567_89AB_CDEF || in_r_resp !== 2'b10 || in_r_last !== 1'b1 || unexp_r !== 1'b0) begin
      errors++; $display("FAIL reset_r_payload: data=%h resp=%b last=%b unexp=%b", in_r_data, in_r_resp, in_r_last, unexp_r);
    end
    clear_inputs();
  endtask

  task automatic test_round_robin;
    do_reset();
    out_ar_ready = 1'b1;
    in_ar_id[3:0] = 4'h5; in_ar_addr[63:0] = 64'h1000; in_ar_len[7:0] = 8'h03;
    in_ar_id[11:8] = 4'h7; in_ar_addr[191:128] = 64'h2_0000; in_ar_len[23:16] = 8'h0F;
    in_ar_valid = 4'b0101;
    #1;
    checks++;
    if (in_ar_ready !== 4'b0001 || out_ar_valid !== 1'b0) begin
      errors++; $display("FAIL rr_first_grant: ready=%b valid=%b exp 0001/0", in_ar_ready, out_ar_valid);
    end
    tick();
    in_ar_valid = 4'b0100;
    #1;
    checks++;
    if (out_ar_valid !== 1'b1 || out_ar_id !== 6'h05 || out_ar_addr !== 64'h1000 || out_ar_len !== 8'h03) begin
      errors++; $display("FAIL rr_first_out: valid=%b id=%h addr=%h len=%h exp 1/05/1000/03", out_ar_valid, out_ar_id, out_ar_addr, out_ar_len);
    end
    checks++;
    if (in_ar_ready !== 4'b0000 || dbg_rr_ptr !== 2'd1) begin
      errors++; $display("FAIL rr_hold_no_ready: ready=%b rr=%0d exp 0000/1", in_ar_ready, dbg_rr_ptr);
    end
    tick();
    checks++;
    if (in_ar_ready !== 4'b0100) begin
      errors++; $display("FAIL rr_second_grant: ready=%b exp 0100", in_ar_ready);
    end
    tick();
    in_ar_valid = '0;
    checks++;
    if (out_ar_id !== 6'h27 || out_ar_stream_id !== 24'hA00002 || out_ar_substream_id !== 20'h00022 ||
        out_ar_ss_id_valid !== 1'b1 || out_ar_addr !== 64'h2_0000 || out_ar_len !== 8'h0F) begin
      errors++; $display("FAIL rr_second_out: id=%h sid=%h ssid=%h ssv=%b addr=%h len=%h exp 27/a00002/00022/1/20000/0f",
        out_ar_id, out_ar_stream_id, out_ar_substream_id, out_ar_ss_id_valid, out_ar_addr, out_ar_len);
    end
    tick();
    checks++;
    if (dbg_count !== 16'h0101 || dbg_rr_ptr !== 2'd3 || out_ar_valid !== 1'b0) begin
      errors++; $display("FAIL rr_counts: cnt=%h rr=%0d valid=%b exp 0101/3/0", dbg_count, dbg_rr_ptr, out_ar_valid);
    end
  endtask

  task automatic test_hold;
    do_reset();
    in_ar_id[7:4] = 4'h3; in_ar_addr[127:64] = 64'hDEAD_BEEF_0000_0040; in_ar_len[15:8] = 8'h07;
    in_ar_id[15:12] = 4'hC; in_ar_addr[255:192] = 64'h3_0000; in_ar_len[31:24] = 8'h01;
    in_ar_valid = 4'b0010;
    #1;
    checks++;
    if (in_ar_ready !== 4'b0010) begin
      errors++; $display("FAIL hold_grant: ready=%b exp 0010", in_ar_ready);
    end
    tick();
    in_ar_valid = 4'b1000;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_ar_valid !== 1'b1 || out_ar_id !== 6'h13 || out_ar_addr !== 64'hDEAD_BEEF_0000_0040 ||
          out_ar_len !== 8'h07 || in_ar_ready !== 4'b0000) begin
        errors++; $display("FAIL hold_stable[%0d]: valid=%b id=%h addr=%h len=%h ready=%b exp 1/13/deadbeef00000040/07/0000",
          c, out_ar_valid, out_ar_id, out_ar_addr, out_ar_len, in_ar_ready);
      end
      tick();
    end
    out_ar_ready = 1'b1;
    tick();
    checks++;
    if (out_ar_valid !== 1'b0 || in_ar_ready !== 4'b1000) begin
      errors++; $display("FAIL hold_release: valid=%b ready=%b exp 0/1000", out_ar_valid, in_ar_ready);
    end
    tick();
    in_ar_valid = '0;
    checks++;
    if (out_ar_valid !== 1'b1 || out_ar_id !== 6'h3C) begin
      errors++; $display("FAIL hold_next_out: valid=%b id=%h exp 1/3c", out_ar_valid, out_ar_id);
    end
    tick();
  endtask

  task automatic test_outstanding;
    int grants;
    do_reset();
    grants = 0;
    out_ar_ready = 1'b1;
    in_ar_valid = 4'b0010;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (in_ar_ready[1] === 1'b1) grants++;
      tick();
    end
    checks++;
    if (grants !== 8 || dbg_count[7:4] !== 4'd8 || in_ar_ready !== 4'b0000) begin
      errors++; $display("FAIL outst_limit: grants=%0d cnt1=%0d ready=%b exp 8/8/0000", grants, dbg_count[7:4], in_ar_ready);
    end
    in_ar_valid = 4'b0011;
    #1;
    checks++;
    if (in_ar_ready !== 4'b0001) begin
      errors++; $display("FAIL outst_other_port: ready=%b exp 0001", in_ar_ready);
    end
    tick();
    in_ar_valid = 4'b0010;
    tick();
    checks++;
    if (in_ar_ready !== 4'b0000 || out_ar_valid !== 1'b0) begin
      errors++; $display("FAIL outst_still_blocked: ready=%b valid=%b exp 0000/0", in_ar_ready, out_ar_valid);
    end
    out_r_valid = 1'b1; out_r_id = 6'h12; out_r_last = 1'b1; in_r_ready = 4'b0010;
    #1;
    checks++;
    if (in_r_valid !== 4'b0010 || out_r_ready !== 1'b1 || unexp_r !== 1'b0) begin
      errors++; $display("FAIL outst_r_route: rvalid=%b rready=%b unexp=%b exp 0010/1/0", in_r_valid, out_r_ready, unexp_r);
    end
    tick();
    out_r_valid = 1'b0; out_r_last = 1'b0; in_r_ready = '0;
    #1;
    checks++;
    if (dbg_count[7:4] !== 4'd7 || in_ar_ready !== 4'b0010) begin
      errors++; $display("FAIL outst_reenable: cnt1=%0d ready=%b exp 7/0010", dbg_count[7:4], in_ar_ready);
    end
    in_ar_valid = '0;
    tick();
  endtask

  task automatic test_simultaneous;
    do_reset();
    out_ar_ready = 1'b1;
    in_ar_id[15:12] = 4'h2;
    in_ar_valid = 4'b1000;
    tick();
    in_ar_valid = '0;
    tick();
    checks++;
    if (dbg_count[15:12] !== 4'd1 || dbg_state !== 1'b0) begin
      errors++; $display("FAIL simul_setup: cnt3=%0d state=%b exp 1/0", dbg_count[15:12], dbg_state);
    end
    in_ar_valid = 4'b1000;
    out_r_valid = 1'b1; out_r_id = 6'h3A; out_r_last = 1'b1; in_r_ready = 4'b1000;
    #1;
    checks++;
    if (in_r_valid !== 4'b1000 || in_r_id !== 4'hA || in_ar_ready !== 4'b1000 || unexp_r !== 1'b0) begin
      errors++; $display("FAIL simul_route: rvalid=%b rid=%h ready=%b unexp=%b exp 1000/a/1000/0",
        in_r_valid, in_r_id, in_ar_ready, unexp_r);
    end
    tick();
    in_ar_valid = '0; out_r_valid = 1'b0; out_r_last = 1'b0; in_r_ready = '0;
    checks++;
    if (dbg_count[15:12] !== 4'd1 || dbg_rr_ptr !== 2'd0) begin
      errors++; $display("FAIL simul_count: cnt3=%0d rr=%0d exp 1/0", dbg_count[15:12], dbg_rr_ptr);
    end
    tick();
  endtask

  task automatic test_unexpected_r;
    do_reset();
    out_r_valid = 1'b1; out_r_id = 6'h01; out_r_last = 1'b1; in_r_ready = 4'b0001;
    #1;
    checks++;
    if (unexp_r !== 1'b1 || in_r_valid !== 4'b0001) begin
      errors++; $display("FAIL unexp_pulse: unexp=%b rvalid=%b exp 1/0001", unexp_r, in_r_valid);
    end
    tick();
    out_r_valid = 1'b0; out_r_last = 1'b0; in_r_ready = '0;
    #1;
    checks++;
    if (unexp_r !== 1'b0 || dbg_count[3:0] !== 4'd0) begin
      errors++; $display("FAIL unexp_after: unexp=%b cnt0=%0d exp 0/0", unexp_r, dbg_count[3:0]);
    end
  endtask

  task automatic test_reset_in_hold;
    do_reset();
    in_ar_valid = 4'b0100;
    #1;
    tick();
    in_ar_valid = '0;
    checks++;
    if (dbg_state !== 1'b1 || out_ar_valid !== 1'b1 || dbg_count[11:8] !== 4'd1 || dbg_rr_ptr !== 2'd3) begin
      errors++; $display("FAIL rsthold_setup: state=%b valid=%b cnt2=%0d rr=%0d exp 1/1/1/3",
        dbg_state, out_ar_valid, dbg_count[11:8], dbg_rr_ptr);
    end
    rst = 1'b1;
    in_ar_valid = 4'b0001;
    tick();
    checks++;
    if (out_ar_valid !== 1'b0 || dbg_state !== 1'b0 || dbg_count !== 16'h0000 || dbg_rr_ptr !== 2'd0 || in_ar_ready !== 4'b0000) begin
      errors++; $display("FAIL rsthold_cleared: valid=%b state=%b cnt=%h rr=%0d ready=%b exp 0/0/0000/0/0000",
        out_ar_valid, dbg_state, dbg_count, dbg_rr_ptr, in_ar_ready);
    end
    rst = 1'b0;
    in_ar_valid = '0;
    tick();
    checks++;
    if (out_ar_valid !== 1'b0) begin
      errors++; $display("FAIL rsthold_abandoned: valid=%b exp 0", out_ar_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    in_ar_id = '0; in_ar_addr = '0; in_ar_len = '0;
    sid_cfg   = {24'hA00003, 24'hA00002, 24'hA00001, 24'hA00000};
    ssid_cfg  = {20'h00033, 20'h00022, 20'h00011, 20'h00000};
    ssidv_cfg = 4'b0100;
    test_reset();
    test_round_robin();
    test_hold();
    test_outstanding();
    test_simultaneous();
    test_unexpected_r();
    test_reset_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
